wb_sync_buffer: RTL
===================

# wb_sync_buffer

Single-clock, parametrised successor to the DDR controller write buffer. It queues user write data of width DW and depth DEPTH, and presents it first-word-fall-through to the memory-side sequencer. It adds what the dual-FIFO buffer lacked:
- an exact occupancy count;
- a burst-ready flag for multi-beat DDR bursts;
- sticky overflow/underflow errors;
- per-byte parity with fault injection in place of the FIFO primitive's ECC.

## Interface
Parameters:
- DW, 128, data width in bits; multiple of 8.
- DEPTH, 512, entries; power of 2, at least 4.
- AFULL_OFFSET, 128, Full asserts when Count >= DEPTH-AFULL_OFFSET; must satisfy 1 <= AFULL_OFFSET < DEPTH.
- BURST, 2, beats per memory burst; 1 <= BURST <= DEPTH.

Ports:
- Clk  in  1  sole clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-high; hold for at least 1 Clk cycle.
- WD  in  DW  write data.
- WRen  in  1  write request.
- InjErr  in  1  when high with an accepted write, byte 0's stored parity bit is inverted.
- Full  out  1  almost-full; the user must not write while it is high.
- MD  out  DW  head entry (FWFT); valid only while Empty=0.
- RDen  in  1  pop request.
- Empty  out  1  no entries.
- BurstReady  out  1  Count >= BURST.
- Count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- ClrErr  in  1  clears the sticky error flags.
- Overflow  out  1  sticky: a write was attempted with Count=DEPTH and no accepted read.
- Underflow  out  1  sticky: RDen was asserted while Empty=1.
- ParityErr  out  1  sticky: a popped word failed its parity check.

## Operation
Storage is DEPTH x (DW + DW/8): data plus one even-parity bit per byte, generated at write time.

Pointers:
- rd_ptr and wr_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Occupancy is tracked by the Count register, not by pointer compare.

Acceptance rules:
- rd_acc = RDen & (Count != 0).
- wr_acc = WRen & (Count != DEPTH | rd_acc). A write at true-full with a simultaneous pop is accepted.
- Full is advisory: writes at Full=1 with Count < DEPTH are accepted.

State updates:
- Count_next = Count + wr_acc - rd_acc.
- On wr_acc: mem[wr_ptr] is written and wr_ptr increments.
- On rd_acc: rd_ptr increments.

Outputs:
- MD = data field of mem[rd_ptr].
- A write to an empty buffer becomes visible on MD/Empty the cycle after acceptance. There is no read-during-write bypass in the same cycle.

Parity check:
- On rd_acc, the parity of MD is recomputed and compared with the stored bits.
- Any mismatch sets ParityErr.
- The data is delivered unmodified.

Error flags:
- Overflow sets when WRen & ~wr_acc.
- Underflow sets when RDen & (Count == 0).
- The flags are sticky until ClrErr. If a set condition coincides with ClrErr, set wins.
- Rejected operations do not change pointers, Count or storage.

Reset:
- Count=0, pointers=0, Empty=1, Full=0, BurstReady=0.
- Overflow=0, Underflow=0, ParityErr=0.
- Storage is not reset.
- MD is undefined until the first write.
- Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.

## Timing
- All flags and Count are registered and computed from Count_next. They reflect the edge at which an operation is accepted, with no extra lag.
- Write-to-read latency: a word accepted at edge N gives Empty=0 and valid MD after edge N; it can be popped at edge N+1.
- Pop-to-next-word: after a pop at edge N, the new head is on MD after edge N.
- There is no combinational path from WRen/RDen to any output. MD depends only on rd_ptr and storage.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then write 0x01..0x05 (DW=128, BURST=2) on consecutive cycles:
  - Count steps 1..5;
  - Empty falls after the first edge;
  - BurstReady rises when Count=2;
  - popping 5 words returns 0x01..0x05 in order and Count returns to 0.
- Fill to DEPTH=512:
  - Full rises when Count=384;
  - the 513th write with RDen=0 is dropped, Overflow=1, Count stays 512;
  - a write with RDen=1 at Count=512 is accepted, Count stays 512 and data order is preserved.
- With Empty=1, pulse RDen:
  - Underflow=1, Count stays 0;
  - ClrErr clears it;
  - ClrErr together with another RDen-while-empty leaves Underflow=1.
- Write 0xA5 with InjErr=1, then 0x5A clean:
  - ParityErr rises only after the first pop;
  - MD carries 0xA5 unmodified;
  - the second pop causes no new error.
- Stream 2000 writes and reads concurrently at full rate through pointer wrap: the output sequence matches the input exactly and Count never exceeds 2.
- Assert Reset mid-stream with Count=37: all flags reach their reset values asynchronously, before the next edge, and the next write produces Count=1.

Source files
------------

// File: rtl/wb_sync_buffer.sv
// wb_sync_buffer: single-clock FWFT write buffer with exact occupancy, burst-ready flag,
// sticky overflow/underflow errors and per-byte even parity with fault injection.
module wb_sync_buffer #(
  parameter int DW           = 128,
  parameter int DEPTH        = 512,
  parameter int AFULL_OFFSET = 128,
  parameter int BURST        = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [DW-1:0]              WD,
  input  logic                       WRen,
  input  logic                       InjErr,
  output logic                       Full,
  output logic [DW-1:0]              MD,
  input  logic                       RDen,
  output logic                       Empty,
  output logic                       BurstReady,
  output logic [$clog2(DEPTH):0]     Count,
  input  logic                       ClrErr,
  output logic                       Overflow,
  output logic                       Underflow,
  output logic                       ParityErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW / 8;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AFULL = (AW+1)'(DEPTH - AFULL_OFFSET);
  localparam logic [AW:0] C_BURST = (AW+1)'(BURST);

  logic [DW+PW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count, w_count_next;
  logic             r_full, r_empty, r_burst, r_ovf, r_udf, r_perr;
  logic             w_rd, w_wr, w_par_bad;
  logic [PW-1:0]    w_wpar, w_rpar;
  logic [DW+PW-1:0] w_head;

  assign w_rd         = RDen & (r_count != '0);
  assign w_wr         = WRen & ((r_count != C_DEPTH) | w_rd);
  assign w_count_next = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
  assign w_head       = r_mem[r_rd_ptr];

  always_comb begin
    w_wpar = '0;
    w_rpar = '0;
    for (int i = 0; i < PW; i++) begin
      w_wpar[i] = ^WD[8*i +: 8];
      w_rpar[i] = ^w_head[8*i +: 8];
    end
  end

  assign w_par_bad = w_rd & (w_rpar != w_head[DW +: PW]);

  // Storage is deliberately left out of reset; InjErr corrupts only byte 0's parity bit.
  always_ff @(posedge Clk)
    if (w_wr) r_mem[r_wr_ptr] <= {w_wpar ^ PW'(InjErr), WD};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_burst  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_empty <= w_count_next == '0;
      r_full  <= w_count_next >= C_AFULL;
      r_burst <= w_count_next >= C_BURST;
      r_ovf   <= (WRen & ~w_wr) | (r_ovf & ~ClrErr);
      r_udf   <= (RDen & (r_count == '0)) | (r_udf & ~ClrErr);
      r_perr  <= w_par_bad | (r_perr & ~ClrErr);
    end
  end

  assign MD         = w_head[DW-1:0];
  assign Count      = r_count;
  assign Empty      = r_empty;
  assign Full       = r_full;
  assign BurstReady = r_burst;
  assign Overflow   = r_ovf;
  assign Underflow  = r_udf;
  assign ParityErr  = r_perr;
endmodule
